// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the pipeline control slice: base opcodes
// used by the hazard logic and the control FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // Drain length after a SYSTEM instruction leaves ID
    localparam logic [1:0] DRAIN_LOAD = 2'd3;

    // Consecutive memory-wait cycles that count as a timeout
    localparam logic [7:0] WAIT_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rs_use_dec.sv
// Decodes which source register fields of the ID instruction are real
// operands, so hazard detection ignores immediate bits in rs1/rs2 slots.
module rs_use_dec
    import riscv_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2
);

    // Opcode lookup; bubbles never read registers
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (valid) begin
            case (opcode)
                LOAD, OP_IMM, JALR: begin
                    use_rs1 = 1'b1;
                end
                OP, STORE, BRANCH: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                JAL, LUI, AUIPC, SYSTEM: begin
                    use_rs1 = 1'b0;
                    use_rs2 = 1'b0;
                end
                default: begin
                    use_rs1 = 1'b0;
                    use_rs2 = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/control unit: memory-wait freeze, branch
// redirect flush, load-use stall, SYSTEM drain-and-halt, a memory timeout
// watchdog and saturating stall/flush performance counters.
module pipeline_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        halted,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    ctrl_state_t state, state_nxt;
    logic [1:0]  drain_cnt, drain_cnt_nxt;
    logic [7:0]  wait_cnt;
    logic        use_rs1, use_rs2;
    logic        load_use, mem_stall, is_system;
    logic        stall_evt, flush_evt;
    logic        unused_inst_bits;

    // funct3/funct7/rd fields play no part in hazard decisions
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

    rs_use_dec u_rs_use_dec (
        .valid   (id_valid),
        .opcode  (id_inst[6:0]),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign mem_stall = mem_req & ~mem_ready;
    assign is_system = id_valid & (id_inst[6:0] == SYSTEM);
    assign load_use  = ex_memread & (ex_rd != 5'd0) &
                       ((use_rs1 & (id_inst[19:15] == ex_rd)) |
                        (use_rs2 & (id_inst[24:20] == ex_rd)));

    // Prioritised control decode and FSM next state: one action per cycle
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        exmem_write   = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_bubble  = 1'b0;
        halted        = 1'b0;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    stall_evt    = 1'b1;
                end else if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_evt  = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_evt  = 1'b1;
                end else if (is_system) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (mem_stall) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    stall_evt    = 1'b1;
                end else begin
                    pc_write      = 1'b0;
                    ifid_flush    = 1'b1;
                    drain_cnt_nxt = drain_cnt - 2'd1;
                    if (drain_cnt <= 2'd1) begin
                        state_nxt = HALTED;
                    end
                end
            end
            HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                halted      = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // FSM state and drain countdown registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Consecutive memory-wait counter with sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else if (mem_stall) begin
            if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_cnt >= WAIT_LIMIT - 8'd1) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Saturating performance counters for applied stalls and flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_evt && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_evt && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl plus hand sequences for
// memory freeze, timeout, drain/halt and reset recovery.
module tb_pipeline_ctrl;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_flush, memwb_bubble;
    logic        halted, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    logic [6:0]  ctl;

    int nChecks = 0;
    int nFails  = 0;

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [6:0] CTL_RUN   = 7'b1111_000;
    localparam logic [6:0] CTL_LU    = 7'b0011_010;
    localparam logic [6:0] CTL_RD    = 7'b1111_110;
    localparam logic [6:0] CTL_MS    = 7'b0000_001;
    localparam logic [6:0] CTL_DRAIN = 7'b0111_100;
    localparam logic [6:0] CTL_HALT  = 7'b0000_000;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        valid;
        logic        memread;
        logic [4:0]  rd;
        logic        redirect;
        logic        req;
        logic        ready;
        logic [6:0]  expCtl;
        int          stallInc;
        int          flushInc;
    } vec_t;

    vec_t vecs[$];

    pipeline_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .exmem_write  (exmem_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_bubble (memwb_bubble),
        .halted       (halted),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign ctl = {pc_write, ifid_write, idex_write, exmem_write,
                  ifid_flush, idex_flush, memwb_bubble};

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mkInst(input logic [6:0] opc, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b0, rd, opc};
    endfunction

    function automatic vec_t mkVec(input string name, input logic [31:0] inst, input logic valid,
                                   input logic memread, input logic [4:0] rd, input logic redirect,
                                   input logic req, input logic ready, input logic [6:0] expCtl,
                                   input int stallInc, input int flushInc);
        vec_t v;
        v.name = name; v.inst = inst; v.valid = valid; v.memread = memread; v.rd = rd;
        v.redirect = redirect; v.req = req; v.ready = ready; v.expCtl = expCtl;
        v.stallInc = stallInc; v.flushInc = flushInc;
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] inst, input logic valid, input logic memread,
                                 input logic [4:0] rd, input logic redirect, input logic req,
                                 input logic ready);
        id_inst     = inst;
        id_valid    = valid;
        ex_memread  = memread;
        ex_rd       = rd;
        ex_redirect = redirect;
        mem_req     = req;
        mem_ready   = ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check combinational controls mid-cycle, then advance one clock
    task automatic doCycle(input string name, input logic [6:0] expCtl, input logic expHalted);
        @(negedge clk);
        checkOutput({name, " ctl"}, 32'(ctl), 32'(expCtl));
        checkOutput({name, " halted"}, 32'(halted), 32'(expHalted));
        tick();
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int expStall;
        int expFlush;

        reset = 1'b0;
        idle();
        tick();
        doReset();

        // Reset state
        checkOutput("reset stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset flush_cnt", 32'(flush_cnt), 32'd0);
        checkOutput("reset mem_timeout", 32'(mem_timeout), 32'd0);
        doCycle("reset idle", CTL_RUN, 1'b0);

        // Vector table: all applied in RUN
        vecs.push_back(mkVec("idle", 32'd0, 0, 0, 5'd0, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("lu add rs1", mkInst(OP, 5'd5, 5'd1, 5'd6), 1, 1, 5'd5, 0, 0, 1, CTL_LU, 1, 0));
        vecs.push_back(mkVec("lu add rs2", mkInst(OP, 5'd1, 5'd5, 5'd6), 1, 1, 5'd5, 0, 0, 1, CTL_LU, 1, 0));
        vecs.push_back(mkVec("lw x0 no lu", mkInst(OP, 5'd0, 5'd0, 5'd6), 1, 1, 5'd0, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("lui no lu", mkInst(LUI, 5'd5, 5'd5, 5'd5), 1, 1, 5'd5, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("bubble no lu", mkInst(OP, 5'd5, 5'd5, 5'd6), 0, 1, 5'd5, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("not load", mkInst(OP, 5'd5, 5'd5, 5'd6), 1, 0, 5'd5, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("lu store rs2", mkInst(STORE, 5'd2, 5'd5, 5'd0), 1, 1, 5'd5, 0, 0, 1, CTL_LU, 1, 0));
        vecs.push_back(mkVec("lu addi rs1", mkInst(OP_IMM, 5'd5, 5'd0, 5'd7), 1, 1, 5'd5, 0, 0, 1, CTL_LU, 1, 0));
        vecs.push_back(mkVec("addi rs2 unused", mkInst(OP_IMM, 5'd1, 5'd5, 5'd7), 1, 1, 5'd5, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("jal no lu", mkInst(JAL, 5'd5, 5'd5, 5'd1), 1, 1, 5'd5, 0, 0, 1, CTL_RUN, 0, 0));
        vecs.push_back(mkVec("lu jalr", mkInst(JALR, 5'd5, 5'd0, 5'd1), 1, 1, 5'd5, 0, 0, 1, CTL_LU, 1, 0));
        vecs.push_back(mkVec("lu branch rs2", mkInst(BRANCH, 5'd3, 5'd5, 5'd0), 1, 1, 5'd5, 0, 0, 1, CTL_LU, 1, 0));
        vecs.push_back(mkVec("redirect", 32'd0, 0, 0, 5'd0, 1, 0, 1, CTL_RD, 0, 1));
        vecs.push_back(mkVec("redirect over lu", mkInst(OP, 5'd5, 5'd1, 5'd6), 1, 1, 5'd5, 1, 0, 1, CTL_RD, 0, 1));
        vecs.push_back(mkVec("mem stall", 32'd0, 0, 0, 5'd0, 0, 1, 0, CTL_MS, 1, 0));
        vecs.push_back(mkVec("mem stall over all", mkInst(OP, 5'd5, 5'd1, 5'd6), 1, 1, 5'd5, 1, 1, 0, CTL_MS, 1, 0));
        vecs.push_back(mkVec("mem ready", 32'd0, 0, 0, 5'd0, 0, 1, 1, CTL_RUN, 0, 0));

        expStall = 0;
        expFlush = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].inst, vecs[i].valid, vecs[i].memread, vecs[i].rd,
                          vecs[i].redirect, vecs[i].req, vecs[i].ready);
            doCycle(vecs[i].name, vecs[i].expCtl, 1'b0);
            expStall += vecs[i].stallInc;
            expFlush += vecs[i].flushInc;
            checkOutput({vecs[i].name, " stall_cnt"}, 32'(stall_cnt), 32'(expStall));
            checkOutput({vecs[i].name, " flush_cnt"}, 32'(flush_cnt), 32'(expFlush));
        end
        idle();
        checkOutput("table mem_timeout", 32'(mem_timeout), 32'd0);

        // Single load-use stall from reset
        doReset();
        applyStimulus(mkInst(OP, 5'd5, 5'd1, 5'd6), 1, 1, 5'd5, 0, 0, 1);
        doCycle("seq lu", CTL_LU, 1'b0);
        idle();
        doCycle("seq lu after", CTL_RUN, 1'b0);
        checkOutput("seq lu stall_cnt", 32'(stall_cnt), 32'd1);

        // Redirect together with load-use
        doReset();
        applyStimulus(mkInst(OP, 5'd5, 5'd1, 5'd6), 1, 1, 5'd5, 1, 0, 1);
        doCycle("seq rd+lu", CTL_RD, 1'b0);
        idle();
        checkOutput("seq rd+lu flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("seq rd+lu stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory freeze holds a pending redirect for four cycles
        doReset();
        applyStimulus(32'd0, 0, 0, 5'd0, 1, 1, 0);
        for (int c = 0; c < 4; c++) doCycle("seq freeze", CTL_MS, 1'b0);
        applyStimulus(32'd0, 0, 0, 5'd0, 1, 1, 1);
        doCycle("seq freeze release", CTL_RD, 1'b0);
        idle();
        checkOutput("seq freeze stall_cnt", 32'(stall_cnt), 32'd4);
        checkOutput("seq freeze flush_cnt", 32'(flush_cnt), 32'd1);

        // Memory timeout after 255 consecutive wait cycles, sticky afterwards
        doReset();
        applyStimulus(32'd0, 0, 0, 5'd0, 0, 1, 0);
        repeat (254) tick();
        checkOutput("timeout at 254", 32'(mem_timeout), 32'd0);
        tick();
        checkOutput("timeout at 255", 32'(mem_timeout), 32'd1);
        checkOutput("timeout stall_cnt", 32'(stall_cnt), 32'd255);
        idle();
        repeat (3) tick();
        checkOutput("timeout sticky", 32'(mem_timeout), 32'd1);

        // Plain ecall drain: three drain cycles then halted
        doReset();
        checkOutput("post-timeout reset", 32'(mem_timeout), 32'd0);
        applyStimulus(mkInst(SYSTEM, 5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 0, 0, 1);
        doCycle("ecall issue", CTL_RUN, 1'b0);
        idle();
        for (int c = 0; c < 3; c++) doCycle("drain", CTL_DRAIN, 1'b0);
        doCycle("halted 1", CTL_HALT, 1'b1);
        doCycle("halted 2", CTL_HALT, 1'b1);

        // Drain with a memory stall and an ignored redirect in the middle
        doReset();
        doCycle("reset from halted", CTL_RUN, 1'b0);
        applyStimulus(mkInst(SYSTEM, 5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 0, 0, 1);
        doCycle("ecall2 issue", CTL_RUN, 1'b0);
        idle();
        doCycle("drain2 d1", CTL_DRAIN, 1'b0);
        applyStimulus(32'd0, 0, 0, 5'd0, 0, 1, 0);
        doCycle("drain2 stall", CTL_MS, 1'b0);
        applyStimulus(32'd0, 0, 0, 5'd0, 1, 0, 1);
        doCycle("drain2 d2 redirect", CTL_DRAIN, 1'b0);
        idle();
        doCycle("drain2 d3", CTL_DRAIN, 1'b0);
        doCycle("drain2 halted", CTL_HALT, 1'b1);
        checkOutput("drain2 stall_cnt", 32'(stall_cnt), 32'd1);
        checkOutput("drain2 flush_cnt", 32'(flush_cnt), 32'd0);
        doReset();
        checkOutput("halted reset stall_cnt", 32'(stall_cnt), 32'd0);
        doCycle("halted reset run", CTL_RUN, 1'b0);

        // Ecall blocked by a redirect stays in RUN
        applyStimulus(mkInst(SYSTEM, 5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 1, 0, 1);
        doCycle("ecall+redirect", CTL_RD, 1'b0);
        idle();
        doCycle("ecall+redirect after", CTL_RUN, 1'b0);

        // Reset in the middle of a drain returns to RUN
        applyStimulus(mkInst(SYSTEM, 5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 0, 0, 1);
        doCycle("ecall3 issue", CTL_RUN, 1'b0);
        idle();
        doCycle("drain3 d1", CTL_DRAIN, 1'b0);
        doReset();
        for (int c = 0; c < 4; c++) doCycle("mid-drain reset run", CTL_RUN, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
